// File: rtl/light_timer_arbiter.sv
// Shared interval timer for the intersection controllers.
// One down-counter, round-robin between highway and country road.
module light_timer_arbiter #(
    parameter int YELLOW_CYCLES = 3,
    parameter int GREEN_CYCLES  = 8,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start_h,
    input  logic sel_h,
    input  logic start_r,
    input  logic sel_r,
    output logic grant_h,
    output logic grant_r,
    output logic busy,
    output logic time_out_h,
    output logic T_out_h,
    output logic time_out_r,
    output logic T_out_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             owner_q, owner_d;
    logic             mode_q,  mode_d;
    logic             last_q,  last_d;
    logic             win;
    logic             done;

    // State register; last resets to 1 so the highway wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            owner_q <= 1'b0;
            mode_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
        end
    end

    // Arbitration, interval load and countdown
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        owner_d = owner_q;
        mode_d  = mode_q;
        last_d  = last_q;
        win     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_h || start_r) begin
                    if (start_h && start_r) begin
                        win = ~last_q;
                    end else begin
                        win = start_r;
                    end
                    owner_d = win;
                    mode_d  = win ? sel_r : sel_h;
                    count_d = mode_d ? G_LOAD : Y_LOAD;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (count_q == '0) begin
                    state_d = DONE;
                    last_d  = owner_q;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        grant_h    = busy & ~owner_q;
        grant_r    = busy & owner_q;
        time_out_h = done & ~owner_q & ~mode_q;
        T_out_h    = done & ~owner_q & mode_q;
        time_out_r = done & owner_q & ~mode_q;
        T_out_r    = done & owner_q & mode_q;
    end

endmodule

// File: tb/tb_light_timer_arbiter.sv
// Directed bench for light_timer_arbiter.
// Default-parameter instance plus a Y=1/G=255 instance.
module tb_light_timer_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_h = 1'b0, sel_h = 1'b0, start_r = 1'b0, sel_r = 1'b0;
    logic start_h2 = 1'b0, sel_h2 = 1'b0, start_r2 = 1'b0, sel_r2 = 1'b0;

    logic gh, gr, bz, toh, Th, tor, Tr;
    logic gh2, gr2, bz2, toh2, Th2, tor2, Tr2;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] ZERO  = 7'b0000000;
    localparam logic [6:0] H_RUN = 7'b1010000;
    localparam logic [6:0] H_YEL = 7'b1011000;
    localparam logic [6:0] H_GRN = 7'b1010100;
    localparam logic [6:0] R_RUN = 7'b0110000;
    localparam logic [6:0] R_YEL = 7'b0110010;
    localparam logic [6:0] R_GRN = 7'b0110001;

    always #5 clk = ~clk;

    light_timer_arbiter dut (
        .clk(clk), .reset(reset),
        .start_h(start_h), .sel_h(sel_h),
        .start_r(start_r), .sel_r(sel_r),
        .grant_h(gh), .grant_r(gr), .busy(bz),
        .time_out_h(toh), .T_out_h(Th),
        .time_out_r(tor), .T_out_r(Tr)
    );

    light_timer_arbiter #(
        .YELLOW_CYCLES(1), .GREEN_CYCLES(255), .CNT_W(8)
    ) dut2 (
        .clk(clk), .reset(reset),
        .start_h(start_h2), .sel_h(sel_h2),
        .start_r(start_r2), .sel_r(sel_r2),
        .grant_h(gh2), .grant_r(gr2), .busy(bz2),
        .time_out_h(toh2), .T_out_h(Th2),
        .time_out_r(tor2), .T_out_r(Tr2)
    );

    wire [6:0] o1 = {gh, gr, bz, toh, Th, tor, Tr};
    wire [6:0] o2 = {gh2, gr2, bz2, toh2, Th2, tor2, Tr2};

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    initial begin
        logic [6:0] e;
        int p;
        int g;

        // reset state
        #1;
        chk("reset_1", o1, ZERO);
        chk("reset_2", o2, ZERO);
        @(negedge clk);
        reset = 1'b1;

        // highway yellow, request held one cycle
        @(negedge clk);
        chk("idle_1", o1, ZERO);
        start_h = 1'b1;
        sel_h   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start_h = 1'b0;
            e = (i < 4) ? H_RUN : (i == 4) ? H_YEL : ZERO;
            chk($sformatf("h_yel_%0d", i), o1, e);
        end

        // country green
        start_r = 1'b1;
        sel_r   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_r = 1'b0;
            e = (i < 9) ? R_RUN : (i == 9) ? R_GRN : ZERO;
            chk($sformatf("r_grn_%0d", i), o1, e);
        end

        // both requesting continuously from reset: alternate h, r
        reset = 1'b0;
        #1;
        chk("rst_idle_async", o1, ZERO);
        start_h = 1'b1;
        start_r = 1'b1;
        sel_h   = 1'b0;
        sel_r   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            p = (k - 1) % 5;
            g = ((k - 1) / 5) % 2;
            if (p == 4)      e = ZERO;
            else if (p == 3) e = g ? R_YEL : H_YEL;
            else             e = g ? R_RUN : H_RUN;
            chk($sformatf("rr_%0d", k), o1, e);
        end
        start_h = 1'b0;
        start_r = 1'b0;

        // drop start and toggle sel mid-interval
        @(negedge clk);
        chk("idle_2", o1, ZERO);
        start_h = 1'b1;
        sel_h   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e = (i < 4) ? H_RUN : (i == 4) ? H_YEL : ZERO;
            chk($sformatf("sel_tog_%0d", i), o1, e);
            start_h = 1'b0;
            sel_h   = ~sel_h;
        end
        sel_h = 1'b0;

        // reset two cycles into a highway green interval
        start_h = 1'b1;
        sel_h   = 1'b1;
        @(negedge clk);
        chk("h_grn_1", o1, H_RUN);
        start_h = 1'b0;
        @(negedge clk);
        chk("h_grn_2", o1, H_RUN);
        reset = 1'b0;
        #1;
        chk("rst_async_run", o1, ZERO);
        start_h = 1'b1;
        start_r = 1'b1;
        sel_h   = 1'b0;
        sel_r   = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold_%0d", i), o1, ZERO);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("tie_after_rst", o1, H_RUN);
        start_h = 1'b0;
        start_r = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_3", o1, ZERO);

        // short/long extremes on the second instance
        start_h2 = 1'b1;
        sel_h2   = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start_h2 = 1'b0;
            e = (i == 1) ? H_RUN : (i == 2) ? H_YEL : ZERO;
            chk($sformatf("y1_%0d", i), o2, e);
        end
        start_r2 = 1'b1;
        sel_r2   = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            @(negedge clk);
            start_r2 = 1'b0;
            e = (i < 256) ? R_RUN : (i == 256) ? R_GRN : ZERO;
            chk($sformatf("g255_%0d", i), o2, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
